// File: rtl/retire_wide.sv
`default_nettype none
// retire_wide: reorder buffer with in-order multi-lane retire, a store/load memory
// port at the head, and mispredict flush. Revision 1.0.
module retire_wide #(
  parameter  int DEPTH    = 16,
  parameter  int RETIRE_W = 2,
  parameter  int DATA_W   = 32,
  parameter  int PRF_AW   = 6,
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  input  logic [1:0]                   alloc_kind,
  input  logic                         alloc_has_dest,
  input  logic [PRF_AW-1:0]            alloc_dest,
  input  logic [PRF_AW-1:0]            alloc_old,
  output logic [IW-1:0]                alloc_idx,
  output logic                         full,
  output logic                         empty,
  output logic [IW:0]                  count,
  input  logic                         cmpl_en,
  input  logic [IW-1:0]                cmpl_idx,
  input  logic [DATA_W-1:0]            cmpl_value,
  input  logic [31:0]                  cmpl_addr,
  input  logic                         cmpl_mispred,
  output logic [RETIRE_W-1:0]          ret_en,
  output logic [RETIRE_W-1:0]          ret_rf_we,
  output logic [RETIRE_W*PRF_AW-1:0]   ret_dest,
  output logic [RETIRE_W*PRF_AW-1:0]   ret_old,
  output logic [RETIRE_W*DATA_W-1:0]   ret_value,
  output logic [RETIRE_W*IW-1:0]       ret_idx,
  output logic                         flush,
  output logic [31:0]                  flush_pc,
  output logic                         dmem_wr_en,
  output logic                         dmem_rd_en,
  output logic [31:0]                  dmem_addr,
  output logic [31:0]                  dmem_wdata,
  input  logic                         dmem_valid,
  input  logic [31:0]                  dmem_rdata
);
  localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_BRANCH = 2'd3;
  localparam logic [1:0] S_FREE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2;

  typedef enum logic {IDLE, LD_WAIT} mem_state_t;
  mem_state_t mstate, mstate_next;

  logic [1:0]        st       [DEPTH];
  logic [1:0]        kind     [DEPTH];
  logic              has_dest [DEPTH];
  logic [PRF_AW-1:0] dest     [DEPTH];
  logic [PRF_AW-1:0] old      [DEPTH];
  logic [DATA_W-1:0] value    [DEPTH];
  logic [31:0]       addr     [DEPTH];
  logic              mispred  [DEPTH];

  logic [IW:0]         head, tail, cnt;
  logic [IW-1:0]       hidx;
  logic [IW-1:0]       lane_idx [RETIRE_W];
  logic [RETIRE_W-1:0] ren;
  logic [2:0]          n_ret;
  logic                head_done, acc, cmpl_ok;

  // Occupancy comes from the wrap-bit pointer difference.
  assign cnt       = tail - head;
  assign hidx      = head[IW-1:0];
  assign count     = cnt;
  assign full      = (cnt == (IW+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign alloc_idx = tail[IW-1:0];
  assign head_done = !empty && (st[hidx] == S_DONE);
  assign acc       = alloc_en && !full && !flush;
  assign cmpl_ok   = cmpl_en && !flush && (st[cmpl_idx] == S_WAIT);

  always_comb begin
    logic go, ok, simple;
    go    = 1'b1;
    ren   = '0;
    n_ret = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      lane_idx[k] = hidx + IW'(k);
      simple = (kind[lane_idx[k]] == K_ALU) ||
               (kind[lane_idx[k]] == K_BRANCH && !mispred[lane_idx[k]]);
      ok = go && (k < int'(cnt)) && (st[lane_idx[k]] == S_DONE);
      if (k == 0 && kind[lane_idx[k]] == K_LOAD)
        ok = ok && (mstate == LD_WAIT) && dmem_valid;
      if (k > 0)
        ok = ok && simple;
      ren[k] = ok;
      if (ok)
        n_ret = n_ret + 3'd1;
      // Stores, loads and mispredicts at the head always retire alone.
      go = ok && simple;
    end
  end

  always_comb begin
    ret_en    = ren;
    ret_rf_we = '0;
    ret_dest  = '0;
    ret_old   = '0;
    ret_value = '0;
    ret_idx   = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (ren[k]) begin
        ret_dest[k*PRF_AW +: PRF_AW] = dest[lane_idx[k]];
        ret_idx[k*IW +: IW]          = lane_idx[k];
        ret_value[k*DATA_W +: DATA_W] = (k == 0 && kind[lane_idx[k]] == K_LOAD) ?
                                        DATA_W'(dmem_rdata) : value[lane_idx[k]];
        if (has_dest[lane_idx[k]] && dest[lane_idx[k]] != '0) begin
          ret_rf_we[k]                = 1'b1;
          ret_old[k*PRF_AW +: PRF_AW] = old[lane_idx[k]];
        end
      end
    end
    flush      = ren[0] && (kind[hidx] == K_BRANCH) && mispred[hidx];
    flush_pc   = flush ? addr[hidx] : 32'd0;
    dmem_wr_en = head_done && (kind[hidx] == K_STORE);
    dmem_rd_en = (mstate == LD_WAIT);
    dmem_addr  = dmem_wr_en ? addr[hidx] : (dmem_rd_en ? 32'(value[hidx]) : 32'd0);
    dmem_wdata = dmem_wr_en ? 32'(value[hidx]) : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mstate <= IDLE;
    else     mstate <= mstate_next;
  end

  always_comb begin
    mstate_next = mstate;
    case (mstate)
      IDLE:    if (head_done && kind[hidx] == K_LOAD) mstate_next = LD_WAIT;
      LD_WAIT: if (dmem_valid) mstate_next = IDLE;
      default: mstate_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) st[i] <= S_FREE;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= S_FREE;
      head <= head + (IW+1)'(1);
      tail <= head + (IW+1)'(1);
    end else begin
      for (int k = 0; k < RETIRE_W; k++)
        if (ren[k]) st[lane_idx[k]] <= S_FREE;
      if (cmpl_ok) st[cmpl_idx] <= S_DONE;
      if (acc) begin
        st[tail[IW-1:0]] <= S_WAIT;
        tail <= tail + (IW+1)'(1);
      end
      head <= head + (IW+1)'(n_ret);
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      kind[tail[IW-1:0]]     <= alloc_kind;
      has_dest[tail[IW-1:0]] <= alloc_has_dest;
      dest[tail[IW-1:0]]     <= alloc_dest;
      old[tail[IW-1:0]]      <= alloc_old;
    end
    if (cmpl_ok) begin
      value[cmpl_idx]   <= cmpl_value;
      addr[cmpl_idx]    <= cmpl_addr;
      mispred[cmpl_idx] <= cmpl_mispred;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_retire_wide.sv
`default_nettype none
// tb_retire_wide: directed and randomized checks of retire_wide against a
// queue-based reorder-buffer model.
module tb_retire_wide;
  localparam int DEPTH = 16, RW = 2, DW = 32, PA = 6, IW = 4;

  logic clk = 1'b0, rst;
  logic alloc_en, alloc_has_dest, cmpl_en, cmpl_mispred, dmem_valid;
  logic [1:0] alloc_kind;
  logic [PA-1:0] alloc_dest, alloc_old;
  logic [IW-1:0] alloc_idx, cmpl_idx;
  logic full, empty, flush, dmem_wr_en, dmem_rd_en;
  logic [IW:0] count;
  logic [DW-1:0] cmpl_value;
  logic [31:0] cmpl_addr, flush_pc, dmem_addr, dmem_wdata, dmem_rdata;
  logic [RW-1:0] ret_en, ret_rf_we;
  logic [RW*PA-1:0] ret_dest, ret_old;
  logic [RW*DW-1:0] ret_value;
  logic [RW*IW-1:0] ret_idx;

  always #5 clk = ~clk;

  retire_wide #(.DEPTH(DEPTH), .RETIRE_W(RW), .DATA_W(DW), .PRF_AW(PA)) dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_kind(alloc_kind), .alloc_has_dest(alloc_has_dest),
    .alloc_dest(alloc_dest), .alloc_old(alloc_old),
    .alloc_idx(alloc_idx), .full(full), .empty(empty), .count(count),
    .cmpl_en(cmpl_en), .cmpl_idx(cmpl_idx), .cmpl_value(cmpl_value),
    .cmpl_addr(cmpl_addr), .cmpl_mispred(cmpl_mispred),
    .ret_en(ret_en), .ret_rf_we(ret_rf_we), .ret_dest(ret_dest), .ret_old(ret_old),
    .ret_value(ret_value), .ret_idx(ret_idx),
    .flush(flush), .flush_pc(flush_pc),
    .dmem_wr_en(dmem_wr_en), .dmem_rd_en(dmem_rd_en), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic [1:0]  kind;
    bit          hd;
    logic [5:0]  dest, old;
    bit          done;
    logic [31:0] value, addr;
    bit          mp;
  } ent_t;

  ent_t q[$];
  int headp = 0;
  bit ldw = 0;
  int n_exp = 0;
  bit fl_exp = 0;
  int checks = 0, errors = 0, ret_total = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit simple(ent_t e);
    return e.kind == 2'd0 || (e.kind == 2'd3 && !e.mp);
  endfunction

  // Expected outputs follow directly from the in-order ROB rules applied to the queue.
  task automatic check_outputs();
    int n = 0;
    bit fl = 0, wr = 0, rd = 0;
    logic [31:0] ad = 0, wd = 0;
    logic [RW-1:0] en_e = '0, we_e = '0;
    if (q.size() > 0 && q[0].done) begin
      case (q[0].kind)
        2'd2: begin n = 1; wr = 1; ad = q[0].addr; wd = q[0].value; end
        2'd1: if (ldw) begin rd = 1; ad = q[0].value; if (dmem_valid) n = 1; end
        2'd3: begin n = 1; fl = q[0].mp; end
        default: n = 1;
      endcase
      if (n == 1 && simple(q[0]))
        while (n < RW && n < q.size() && q[n].done && simple(q[n])) n++;
    end
    for (int k = 0; k < n; k++) begin
      en_e[k] = 1'b1;
      we_e[k] = q[k].hd && q[k].dest != 0;
    end
    chk("ret_en", ret_en, en_e);
    chk("ret_rf_we", ret_rf_we, we_e);
    for (int k = 0; k < n; k++) begin
      chk("ret_dest", ret_dest[k*PA +: PA], q[k].dest);
      chk("ret_idx", ret_idx[k*IW +: IW], (headp + k) % DEPTH);
      chk("ret_value", ret_value[k*DW +: DW], (k == 0 && q[0].kind == 2'd1) ? dmem_rdata : q[k].value);
      if (we_e[k]) chk("ret_old", ret_old[k*PA +: PA], q[k].old);
    end
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("alloc_idx", alloc_idx, (headp + q.size()) % DEPTH);
    chk("flush", flush, fl);
    if (fl) chk("flush_pc", flush_pc, q[0].addr);
    chk("dmem_wr_en", dmem_wr_en, wr);
    chk("dmem_rd_en", dmem_rd_en, rd);
    if (wr || rd) chk("dmem_addr", dmem_addr, ad);
    if (wr) chk("dmem_wdata", dmem_wdata, wd);
    ret_total += $countones(ret_en);
    n_exp = n;
    fl_exp = fl;
  endtask

  task automatic advance();
    bit ldw_n, aok;
    int pos;
    ent_t e;
    ldw_n = ldw;
    if (ldw && dmem_valid) ldw_n = 0;
    else if (!ldw && q.size() > 0 && q[0].done && q[0].kind == 2'd1) ldw_n = 1;
    if (fl_exp) begin
      q.delete();
      headp = (headp + 1) % DEPTH;
      ldw = 0;
      return;
    end
    if (cmpl_en) begin
      pos = (int'(cmpl_idx) - headp + DEPTH) % DEPTH;
      if (pos < q.size() && !q[pos].done) begin
        q[pos].done = 1; q[pos].value = cmpl_value; q[pos].addr = cmpl_addr; q[pos].mp = cmpl_mispred;
      end
    end
    aok = alloc_en && q.size() < DEPTH;
    for (int k = 0; k < n_exp; k++) q.delete(0);
    headp = (headp + n_exp) % DEPTH;
    if (aok) begin
      e.kind = alloc_kind; e.hd = alloc_has_dest; e.dest = alloc_dest; e.old = alloc_old;
      e.done = 0; e.value = 0; e.addr = 0; e.mp = 0;
      q.push_back(e);
    end
    ldw = ldw_n;
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_en = 0; alloc_kind = 0; alloc_has_dest = 0; alloc_dest = 0; alloc_old = 0;
    cmpl_en = 0; cmpl_idx = 0; cmpl_value = 0; cmpl_addr = 0; cmpl_mispred = 0;
    dmem_valid = 0; dmem_rdata = 0;
  endtask

  task automatic alloc(logic [1:0] k, logic hd, logic [5:0] d, logic [5:0] o);
    alloc_en = 1; alloc_kind = k; alloc_has_dest = hd; alloc_dest = d; alloc_old = o;
  endtask

  task automatic cmpl(logic [3:0] idx, logic [31:0] v, logic [31:0] a, logic mp);
    cmpl_en = 1; cmpl_idx = idx; cmpl_value = v; cmpl_addr = a; cmpl_mispred = mp;
  endtask

  task automatic model_reset();
    q.delete(); headp = 0; ldw = 0; n_exp = 0; fl_exp = 0;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_ret_en"}, ret_en, 0);
    chk({tag, "_ret_dest"}, ret_dest, 0);
    chk({tag, "_ret_value"}, ret_value, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_alloc_idx"}, alloc_idx, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_rd_en"}, dmem_rd_en, 0);
    chk({tag, "_wr_en"}, dmem_wr_en, 0);
  endtask

  // Called at a negedge (or time 0); leaves the bench at a negedge with rst low.
  task automatic apply_reset();
    idle();
    rst = 1;
    #1;
    reset_checks("rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int rdc;
    bit got;
    int pos;
    apply_reset();

    // Two ALU ops retire together once the older one completes.
    idle(); alloc(2'd0, 1, 6'd5, 6'd1); step();
    idle(); alloc(2'd0, 1, 6'd6, 6'd2); step();
    idle(); cmpl(4'd1, 32'h11, 0, 0); step();
    idle(); cmpl(4'd0, 32'h10, 0, 0); #1;
    chk("pair_count_before", count, 2);
    step();
    idle(); #1;
    chk("pair_ret_en", ret_en, 2'b11);
    chk("pair_ret_dest", ret_dest, {6'd6, 6'd5});
    step();
    idle(); #1;
    chk("pair_count_after", count, 0);
    step();

    // Fill to capacity; the extra allocation is dropped.
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      idle(); alloc(2'd0, 1, 6'(i + 1), 6'd0); step();
    end
    idle(); #1;
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_alloc_idx", alloc_idx, 0);
    step();

    // Store retires alone and drives the write port.
    apply_reset();
    idle(); alloc(2'd2, 0, 6'd0, 6'd0); step();
    idle(); alloc(2'd0, 1, 6'd3, 6'd4); step();
    idle(); cmpl(4'd1, 32'h77, 0, 0); step();
    idle(); cmpl(4'd0, 32'hCAFE, 32'h200, 0); step();
    idle(); #1;
    chk("store_wr_en", dmem_wr_en, 1);
    chk("store_ret_en", ret_en, 2'b01);
    step();
    idle(); step();

    // Load waits for memory; stray dmem_valid before the wait is ignored.
    apply_reset();
    idle(); alloc(2'd1, 1, 6'd7, 6'd8); step();
    idle(); alloc(2'd0, 1, 6'd9, 6'd10); step();
    idle(); cmpl(4'd1, 32'h55, 0, 0); step();
    idle(); cmpl(4'd0, 32'h100, 0, 0); dmem_valid = 1; dmem_rdata = 32'h1234; step();
    rdc = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      idle(); #1;
      if (dmem_rd_en) begin
        rdc++;
        if (rdc == 3) begin
          dmem_valid = 1; dmem_rdata = 32'hDEAD; got = 1; #1;
          chk("load_ret_value", ret_value[DW-1:0], 32'hDEAD);
          chk("load_ret_en", ret_en, 2'b01);
        end
      end
      step();
    end
    chk("load_rd_cycles", rdc, 3);
    idle(); step();
    idle(); step();

    // Mispredicted branch at the head flushes everything behind it.
    apply_reset();
    idle(); alloc(2'd3, 0, 6'd0, 6'd0); step();
    for (int i = 0; i < 3; i++) begin
      idle(); alloc(2'd0, 1, 6'(i + 20), 6'd0); step();
    end
    for (int i = 1; i < 4; i++) begin
      idle(); cmpl(4'(i), 32'(i), 0, 0); step();
    end
    idle(); cmpl(4'd0, 32'h0, 32'h4000, 1); step();
    idle(); alloc(2'd0, 1, 6'd9, 6'd0); cmpl(4'd1, 32'h9, 0, 0); #1;
    chk("br_flush", flush, 1);
    chk("br_flush_pc", flush_pc, 32'h4000);
    chk("br_ret_en", ret_en, 2'b01);
    step();
    idle(); #1;
    chk("br_empty_after", empty, 1);
    step();

    // Steady alloc/retire stream wraps the pointers.
    apply_reset();
    ret_total = 0;
    for (int i = 0; i < 40; i++) begin
      idle(); alloc(2'd0, 1, 6'((i % 31) + 1), 6'(i % 7));
      if (i > 0) cmpl(4'((i - 1) % 16), 32'(i), 0, 0);
      step();
    end
    idle(); cmpl(4'(39 % 16), 32'd40, 0, 0); step();
    for (int i = 0; i < 3; i++) begin idle(); step(); end
    chk("wrap_retired", ret_total, 40);
    chk("wrap_empty", empty, 1);

    // Reset during a load wait abandons it immediately.
    apply_reset();
    idle(); alloc(2'd1, 1, 6'd2, 6'd3); step();
    idle(); cmpl(4'd0, 32'h300, 0, 0); step();
    idle(); step();
    idle(); #1;
    chk("ldrst_rd_before", dmem_rd_en, 1);
    rst = 1; #1;
    chk("ldrst_rd_now", dmem_rd_en, 0);
    chk("ldrst_empty", empty, 1);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin idle(); dmem_valid = 1; step(); end

    // Randomized traffic against the model.
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      idle();
      if ($urandom_range(2) != 0)
        alloc(2'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
      if (q.size() > 0 && $urandom_range(1) == 1) begin
        pos = $urandom_range(q.size() - 1);
        cmpl(4'((headp + pos) % DEPTH), $urandom, $urandom, $urandom_range(5) == 0);
      end
      dmem_valid = ($urandom_range(2) == 0);
      dmem_rdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
